// File: rtl/wvg_pkg.sv
// Shared types and constants for the weight-constrained vector generator.
// Holds the FSM state encoding, the width ceiling and a binomial helper.
package wvg_pkg;

    localparam int MAX_VEC_WIDTH = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of vectors of width n with exactly k ones, i.e. beats in one run.
    function automatic int n_choose_k(input int n, input int k);
        longint r;
        r = 1;
        if (k < 0 || k > n) begin
            return 0;
        end
        for (int i = 0; i < k; i++) begin
            r = r * longint'(n - i) / longint'(i + 1);
        end
        return int'(r);
    endfunction

endpackage

// File: rtl/wvg_gosper_next.sv
// Next larger vector with the same popcount (Gosper's hack), purely combinational.
// Zero latency, no flow control; the caller never presents 0 or the final vector of a run.
module wvg_gosper_next #(
    parameter int VEC_WIDTH = 6
) (
    input  logic [VEC_WIDTH-1:0] v,
    output logic [VEC_WIDTH-1:0] next
);

    localparam int CW = $clog2(VEC_WIDTH + 1);

    logic [VEC_WIDTH:0] v_ext;
    logic [VEC_WIDTH:0] c;
    logic [VEC_WIDTH:0] r;
    logic [VEC_WIDTH:0] t;
    logic [CW-1:0]      ctz;

    always_comb begin
        v_ext = {1'b0, v};
        c     = v_ext & (~v_ext + 1'b1);
        r     = v_ext + c;
        // c is one-hot, so this priority encoder replaces the divide by c.
        ctz   = '0;
        for (int i = VEC_WIDTH - 1; i >= 0; i--) begin
            if (c[i]) begin
                ctz = CW'(i);
            end
        end
        t     = ((r ^ v_ext) >> 2) >> ctz;
        next  = VEC_WIDTH'(r | t);
    end

endmodule

// File: rtl/weight_vector_gen.sv
// Streams every VEC_WIDTH-bit vector of popcount k in ascending order, one beat per clock.
// First beat 1 clk after command accept; all stream outputs hold while m_valid && !m_ready.
module weight_vector_gen
    import wvg_pkg::*;
#(
    parameter int VEC_WIDTH = 6,
    parameter int CNT_WIDTH = $clog2(VEC_WIDTH + 1),
    parameter int IDX_WIDTH = VEC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CNT_WIDTH-1:0] cmd_weight,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [VEC_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic [IDX_WIDTH-1:0] m_index,
    output logic                 err
);

    generate
        if (VEC_WIDTH < 1 || VEC_WIDTH > MAX_VEC_WIDTH) begin : g_bad_width
            $fatal(1, "weight_vector_gen: VEC_WIDTH must be in 1..16");
        end
    endgenerate

    function automatic logic [VEC_WIDTH-1:0] low_ones(input int k);
        logic [VEC_WIDTH-1:0] ones;
        ones = '1;
        return ~(ones << k);
    endfunction

    function automatic logic [VEC_WIDTH-1:0] high_ones(input int k);
        logic [VEC_WIDTH-1:0] ones;
        ones = '1;
        return ones << (VEC_WIDTH - k);
    endfunction

    state_t               state;
    logic [CNT_WIDTH-1:0] k_q;
    logic [VEC_WIDTH-1:0] gnext;
    logic [VEC_WIDTH-1:0] first_pat;
    logic                 first_is_last;
    logic                 weight_ok;

    wvg_gosper_next #(
        .VEC_WIDTH (VEC_WIDTH)
    ) u_next (
        .v    (m_data),
        .next (gnext)
    );

    always_comb begin
        weight_ok     = int'(cmd_weight) <= VEC_WIDTH;
        first_pat     = low_ones(int'(cmd_weight));
        first_is_last = first_pat == high_ones(int'(cmd_weight));
    end

    // Gated by rst so that a held reset never advertises readiness.
    assign cmd_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k_q     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_index <= '0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    if (weight_ok) begin
                        state   <= RUN;
                        k_q     <= cmd_weight;
                        m_valid <= 1'b1;
                        m_data  <= first_pat;
                        m_index <= '0;
                        m_last  <= first_is_last;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (m_ready) begin
                if (m_last) begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end else begin
                    m_data  <= gnext;
                    m_index <= m_index + IDX_WIDTH'(1);
                    m_last  <= gnext == high_ones(int'(k_q));
                end
            end
        end
    end

    a_popcount: assert property (@(posedge clk) disable iff (rst)
        m_valid |-> ($countones(m_data) == int'(k_q)));

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_index) && $stable(m_last)));

endmodule

// File: tb/tb_weight_vector_gen.sv
// Scoreboarded bench: a popcount-filtered enumeration model feeds expected-beat queues,
// independent monitors pop and compare every accepted beat of an N=6 and an N=8 instance.
module tb_weight_vector_gen;
    import wvg_pkg::*;

    typedef struct {
        logic [15:0] data;
        int          idx;
        bit          last;
    } beat_t;
    typedef beat_t beat_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cmd_valid, cmd_ready, m_valid, m_ready, m_last, err;
    logic [2:0] cmd_weight;
    logic [5:0] m_data, m_index;

    logic       cmd_valid8, cmd_ready8, m_valid8, m_ready8, m_last8, err8;
    logic [3:0] cmd_weight8;
    logic [7:0] m_data8, m_index8;

    int      errs = 0;
    int      checks = 0;
    beat_q_t exp_q, exp_q8;
    beat_t   mb6, mb8;
    bit      rand_ready = 1'b0;
    int      seen8[256];
    int      beats8 = 0;

    weight_vector_gen #(.VEC_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_weight(cmd_weight), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_index(m_index), .err(err)
    );

    weight_vector_gen #(.VEC_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
        .cmd_weight(cmd_weight8), .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8),
        .m_last(m_last8), .m_index(m_index8), .err(err8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errs++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Every n-bit value with popcount k, in ascending numeric order.
    function automatic beat_q_t model(input int n, input int k);
        beat_q_t q;
        beat_t   b;
        for (int v = 0; v < (1 << n); v++) begin
            if ($countones(v) == k) begin
                b.data = 16'(v);
                b.idx  = q.size();
                b.last = 1'b0;
                q.push_back(b);
            end
        end
        if (q.size() > 0) q[q.size() - 1].last = 1'b1;
        return q;
    endfunction

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // N=6 monitor: scoreboard pop plus hold-under-stall checking.
    logic [5:0] prev_data, prev_idx;
    bit         prev_last;
    bit         prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {m_valid, m_last, m_index, m_data},
                      {1'b1, prev_last, prev_idx, prev_data});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_beat: got data 0x%0h, none expected", m_data);
                end else begin
                    mb6 = exp_q.pop_front();
                    check("beat_data", m_data, mb6.data);
                    check("beat_index", m_index, mb6.idx);
                    check("beat_last", m_last, mb6.last);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
            prev_last  = m_last;
        end
    end

    // N=8 monitor for the exhaustive sweep.
    always @(negedge clk) begin
        if (!rst && m_valid8 && m_ready8) begin
            seen8[m_data8]++;
            beats8++;
            if (exp_q8.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_beat8: got data 0x%0h, none expected", m_data8);
            end else begin
                mb8 = exp_q8.pop_front();
                check("beat8_data", m_data8, mb8.data);
                check("beat8_index", m_index8, mb8.idx);
                check("beat8_last", m_last8, mb8.last);
            end
        end
    end

    task automatic wait_idle6();
        int n = 0;
        @(negedge clk);
        #1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) timeout("wait_cmd_ready");
    endtask

    task automatic drain6(input string name, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            timeout(name);
            exp_q.delete();
        end
    endtask

    task automatic run6(input int k, input bit rnd);
        beat_q_t t;
        int      n;
        t = model(6, k);
        rand_ready = rnd;
        foreach (t[i]) exp_q.push_back(t[i]);
        wait_idle6();
        cmd_valid  = 1'b1;
        cmd_weight = 3'(k);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        check("first_beat_latency", m_valid, 1);
        drain6("run_drain", n);
        if (!rnd) check("beats_one_per_clk", n + 1, n_choose_k(6, k));
        @(negedge clk);
        #1;
        check("cmd_ready_after_last", cmd_ready, 1);
        check("valid_low_after_last", m_valid, 0);
    endtask

    task automatic run8(input int k);
        beat_q_t t;
        int      n = 0;
        t = model(8, k);
        foreach (t[i]) exp_q8.push_back(t[i]);
        @(negedge clk);
        #1;
        while (!cmd_ready8 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        cmd_valid8  = 1'b1;
        cmd_weight8 = 4'(k);
        @(posedge clk);
        #1;
        cmd_valid8 = 1'b0;
        n = 0;
        while (exp_q8.size() != 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q8.size() != 0) begin
            timeout("run8_drain");
            exp_q8.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_q_t t;
        int      n;
        int      bad;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_weight  = '0;
        cmd_valid8  = 1'b0;
        cmd_weight8 = '0;
        m_ready8    = 1'b1;
        foreach (seen8[i]) seen8[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_index", m_index, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        #1;
        check("cmd_ready_after_rst", cmd_ready, 1);

        run6(2, 1'b0);
        run6(0, 1'b0);
        run6(6, 1'b0);

        // Over-range weight: rejected with a one-cycle err pulse.
        wait_idle6();
        cmd_valid  = 1'b1;
        cmd_weight = 3'd7;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        check("err_pulse", err, 1);
        check("err_no_valid", m_valid, 0);
        check("err_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        #1;
        check("err_one_cycle", err, 0);
        check("err_no_valid_next", m_valid, 0);
        check("err_cmd_ready_next", cmd_ready, 1);

        run6(3, 1'b1);

        // Reset in the middle of a k=3 run, after five beats have been accepted.
        rand_ready = 1'b0;
        t = model(6, 3);
        foreach (t[i]) exp_q.push_back(t[i]);
        wait_idle6();
        cmd_valid  = 1'b1;
        cmd_weight = 3'd3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 15 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 15) timeout("midrun_wait");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrun_rst_valid", m_valid, 0);
        check("midrun_rst_index", m_index, 0);
        check("midrun_rst_last", m_last, 0);
        check("midrun_rst_cmd_ready", cmd_ready, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run6(1, 1'b0);

        // cmd_valid held through a run: the follow-on command waits for IDLE.
        rand_ready = 1'b0;
        t = model(6, 2);
        foreach (t[i]) exp_q.push_back(t[i]);
        t = model(6, 1);
        foreach (t[i]) exp_q.push_back(t[i]);
        wait_idle6();
        cmd_valid  = 1'b1;
        cmd_weight = 3'd2;
        @(posedge clk);
        #1;
        cmd_weight = 3'd1;
        @(negedge clk);
        #1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("held_cmd_busy_cycles", n, 15);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drain6("held_cmd_drain", n);
        @(negedge clk);
        #1;
        check("held_cmd_idle", cmd_ready, 1);

        for (int i = 0; i < 4; i++) begin
            run6(int'($urandom_range(0, 6)), 1'b1);
        end
        rand_ready = 1'b0;

        for (int k = 0; k <= 8; k++) begin
            run8(k);
        end
        check("sweep_total_beats", beats8, 256);
        bad = 0;
        foreach (seen8[i]) if (seen8[i] != 1) bad++;
        check("sweep_each_once", bad, 0);
        check("scoreboard_empty", exp_q.size() + exp_q8.size(), 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
